alu_mdu: RTL and testbench
==========================

// Module: alu_mdu
// PURPOSE
//  Parametrised next-generation execute unit: single-cycle integer ALU ops (add/sub/logic/compare/shift)
//  plus iterative multiply and divide, behind a valid/ready handshake with registered result and flags.
//  Sits in the EX stage; the core stalls on in_ready=0. Ops 0000-0011 and 0101 keep the legacy 3-bit ALU encoding.
// PARAMETERS
//  WIDTH    32               operand/result width, >=8, power of two
//  SHAMT_W  $clog2(WIDTH)    derived shift-amount width; do not override
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-low reset
//  in_valid   in   1      operation offered
//  in_ready   out  1      unit accepts operation this cycle
//  op         in   4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLTU,7 SLL,8 SRL,9 SRA,A MUL,B MULH,C DIV,D DIVU,E REM,F REMU
//  a, b       in   WIDTH  operands (shifts use b[SHAMT_W-1:0])
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  negative   out  1      result[WIDTH-1]
//  carry      out  1      ADD: carry-out; SUB: carry of a+~b+1 (1 = no borrow); else 0
//  overflow   out  1      signed overflow for ADD/SUB only; else 0
//  busy       out  1      MUL/DIV iteration in progress
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE, out_valid=0, result=0, all flags 0, busy=0; aborts any iteration, no output.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready) - combinational.
//  Output release = out_valid & out_ready; a new result may load in the same cycle (back-to-back, 1 op/cycle).
//  FSM: IDLE -> (accept single-cycle op or div special case) IDLE, result loaded, out_valid=1 next cycle.
//       IDLE -> (accept MUL/MULH) MUL: WIDTH shift-add iterations -> DONE.
//       IDLE -> (accept DIV*/REM*) DIV: WIDTH restoring iterations on magnitudes -> FIX (sign fixup, 1 cycle) -> DONE.
//       DONE: load result/flags, out_valid=1, -> IDLE. busy=1 in MUL, DIV, FIX.
//  Latency (accept cycle N): single-cycle ops out_valid at N+1; MUL/MULH at N+WIDTH+1; DIV/REM at N+WIDTH+2.
//  Arithmetic: ADD/SUB on WIDTH+1 bits; SLT signed, SLTU unsigned, result {0..0,bit}. SRA sign-fills.
//  MUL = low WIDTH of a*b; MULH = high WIDTH of signed*signed (2*WIDTH product).
//  DIV/REM signed truncate toward zero, remainder takes dividend sign; DIVU/REMU unsigned.
//  Divide by zero (1-cycle): quotient all-ones, remainder = a. Signed overflow (a=MIN, b=-1): quotient=MIN, rem=0.
//  Flags are computed from the final result in the cycle it loads; they never change while out_valid=1 and out_ready=0.
//  Operands/op are captured at accept; input changes afterwards have no effect.
//  in_valid while busy: ignored (in_ready=0); producer must hold.
// STRUCTURE
//  Package alu_pkg: op localparams (OP_ADD..OP_REMU), FSM state encoding (IDLE,MUL,DIV,FIX,DONE), is_muldiv(op) function.
//  Sub-module alu_muldiv_iter: iterative shift-add multiplier / restoring divider sharing one 2*WIDTH accumulator,
//  start/done interface, WIDTH-cycle count; top holds handshake, single-cycle ALU datapath, flags, output register.
// TESTING
//  ADD a=0x7FFFFFFF b=1 -> result 0x80000000, overflow=1, negative=1, carry=0, zero=0, out_valid at N+1.
//  SUB a=5 b=5 -> result 0, zero=1, carry=1; SLTU a=1 b=0xFFFFFFFF -> 1; SRA 0x80000000 by 4 -> 0xF8000000.
//  MULH a=0xFFFFFFFF b=0xFFFFFFFF -> 0; MUL a=0x10000 b=0x10000 -> 0; out_valid exactly at N+33, busy high 32 cycles.
//  DIV a=-7 b=2 -> -3, REM -> -1; DIVU a=7 b=0 -> 0xFFFFFFFF (N+1); DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
//  Backpressure: out_ready=0 for 5 cycles after result -> result/flags stable, in_ready=0; then ADD back-to-back 4 ops, 1/cycle.
//  rst low mid-DIV (cycle N+10) -> out_valid=0, result=0, busy=0 immediately; after release in_ready=1, next op correct.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings, execute-unit FSM states and opcode classification helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_SLTU = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_SRA  = 4'h9;
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_MULH = 4'hB;
    localparam logic [3:0] OP_DIV  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_REM  = 4'hE;
    localparam logic [3:0] OP_REMU = 4'hF;

    // DONE names the result-load step; it coincides with the last MUL
    // iteration or with FIX, so the register never rests in it.
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return op >= OP_MUL;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative shift-add multiplier / restoring divider on unsigned magnitudes.
//  clk, rst    clock, asynchronous active-low reset
//  start       load a (into low accumulator half) and b, run WIDTH iterations
//  mul         1 = multiply, 0 = divide (sampled at start)
//  a, b        unsigned operands (multiplier/multiplicand or dividend/divisor)
//  acc         accumulator: product, or {remainder, quotient} once finished
//  nxt         accumulator value after the current iteration
//  done        the current cycle performs the final iteration
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mul,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] nxt,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic             run;
    logic             mode;
    logic [WIDTH-1:0] d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] rdiff;
    logic             fits;

    assign done = run & (cnt == CW'(WIDTH - 1));

    // Multiply adds into the high half then shifts right; divide shifts the
    // partial remainder left and subtracts when the divisor fits. The true
    // difference is below 2^WIDTH, so a WIDTH-bit subtraction suffices.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, d} : '0);
        rsh   = acc[2*WIDTH-1:WIDTH-1];
        fits  = rsh >= {1'b0, d};
        rdiff = rsh[WIDTH-1:0] - d;
        nxt   = mode ? {sum, acc[WIDTH-1:1]}
              : fits ? {rdiff, acc[WIDTH-2:0], 1'b1}
              : {acc[2*WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run  <= 1'b0;
            cnt  <= '0;
            mode <= 1'b0;
            d    <= '0;
            acc  <= '0;
        end else if (start) begin
            run  <= 1'b1;
            cnt  <= '0;
            mode <= mul;
            d    <= b;
            acc  <= {{WIDTH{1'b0}}, a};
        end else if (run) begin
            acc <= nxt;
            cnt <= cnt + 1'b1;
            run <= ~done;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with iterative MUL/DIV behind a valid/ready handshake, registered result and flags.
//  clk, rst               clock, asynchronous active-low reset
//  in_valid, in_ready     operation handshake (in_ready combinational)
//  op, a, b               opcode (alu_pkg OP_*) and operands, captured at accept
//  out_valid, out_ready   result handshake; result/flags held until released
//  result                 registered result
//  zero, negative         result == 0, result sign bit
//  carry, overflow        ADD/SUB carry-out and signed overflow, else 0
//  busy                   multiply/divide iteration in progress
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             state, state_nxt;
    logic [3:0]         op_q;
    logic               q_neg, r_neg;
    logic               accept, sgn, dz, dov, iter, is_mul, done, ld, alu_c, alu_v;
    logic [WIDTH-1:0]   a_mag, b_mag, alu_res, ld_res, quo, rem;
    logic [WIDTH:0]     add_s, sub_s;
    logic [2*WIDTH-1:0] acc, nxt, prod;

    assign in_ready = (state == IDLE) & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = (state == MUL) | (state == DIV) | (state == FIX);

    // Divide by zero and MIN/-1 are resolved in the single-cycle datapath.
    always_comb begin
        sgn    = ~(op == OP_DIVU | op == OP_REMU);
        is_mul = op == OP_MUL | op == OP_MULH;
        dz     = b == '0;
        dov    = sgn & (a == MIN) & (b == '1);
        iter   = is_muldiv(op) & (is_mul | ~(dz | dov));
        a_mag  = sgn & a[WIDTH-1] ? -a : a;
        b_mag  = sgn & b[WIDTH-1] ? -b : b;
        add_s  = {1'b0, a} + {1'b0, b};
        sub_s  = {1'b0, a} - {1'b0, b};
        alu_c  = op == OP_ADD ? add_s[WIDTH] : op == OP_SUB ? ~sub_s[WIDTH] : 1'b0;
        alu_v  = op == OP_ADD ? (a[WIDTH-1] == b[WIDTH-1]) & (add_s[WIDTH-1] != a[WIDTH-1])
               : op == OP_SUB ? (a[WIDTH-1] != b[WIDTH-1]) & (sub_s[WIDTH-1] != a[WIDTH-1])
               : 1'b0;
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:            alu_res = add_s[WIDTH-1:0];
            OP_SUB:            alu_res = sub_s[WIDTH-1:0];
            OP_AND:            alu_res = a & b;
            OP_OR:             alu_res = a | b;
            OP_XOR:            alu_res = a ^ b;
            OP_SLT:            alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:           alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLL:            alu_res = a << b[SHAMT_W-1:0];
            OP_SRL:            alu_res = a >> b[SHAMT_W-1:0];
            OP_SRA:            alu_res = $signed(a) >>> b[SHAMT_W-1:0];
            OP_DIV, OP_DIVU:   alu_res = dz ? '1 : a;
            OP_REM, OP_REMU:   alu_res = dz ? a : '0;
            default:           alu_res = '0;
        endcase
    end

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept & iter),
        .mul   (is_mul),
        .a     (a_mag),
        .b     (b_mag),
        .acc   (acc),
        .nxt   (nxt),
        .done  (done)
    );

    // The product is taken from the final iteration combinationally so MUL
    // loads on its last busy cycle; division needs the extra FIX cycle.
    always_comb begin
        prod      = q_neg ? -nxt : nxt;
        quo       = q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem       = r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        ld        = (accept & ~iter) | (state == MUL & done) | (state == FIX);
        ld_res    = state == MUL ? (op_q == OP_MUL ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH])
                  : state == FIX ? ((op_q == OP_DIV | op_q == OP_DIVU) ? quo : rem)
                  : alu_res;
        state_nxt = state == IDLE ? (accept & iter ? (is_mul ? MUL : DIV) : IDLE)
                  : state == MUL  ? (done ? IDLE : MUL)
                  : state == DIV  ? (done ? FIX : DIV)
                  : IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            op_q      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= op;
                q_neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg <= sgn & a[WIDTH-1];
            end
            if (ld) begin
                out_valid <= 1'b1;
                result    <= ld_res;
                zero      <= ld_res == '0;
                negative  <= ld_res[WIDTH-1];
                carry     <= (state == IDLE) & alu_c;
                overflow  <= (state == IDLE) & alu_v;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: randomized scoreboard bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, zero, negative, carry, overflow, busy;
    logic [W-1:0] result;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .negative(negative), .carry(carry), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           due;
    } exp_t;

    exp_t q[$];
    int   acc_log[$];
    int   cyc = 0, checks = 0, failures = 0, rmode = 1;
    bit   seen = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (rmode == 2) out_ready = 1'($urandom_range(0, 1));
        else out_ready = (rmode == 1);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int n);
        exp_t   e;
        longint sx, sy, s;
        logic [63:0] p;
        logic [W-1:0] r;
        logic c, v;
        int lat;
        sx = $signed(x);
        sy = $signed(y);
        p = 64'(sx * sy);
        c = 1'b0;
        v = 1'b0;
        lat = 1;
        r = '0;
        case (o)
            OP_ADD:  begin s = sx + sy; r = x + y; c = (64'(x) + 64'(y)) > 64'hFFFF_FFFF; v = s > 64'sd2147483647 || s < -64'sd2147483648; end
            OP_SUB:  begin s = sx - sy; r = x - y; c = x >= y; v = s > 64'sd2147483647 || s < -64'sd2147483648; end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = (sx < sy) ? 1 : 0;
            OP_SLTU: r = (x < y) ? 1 : 0;
            OP_SLL:  r = x << y[4:0];
            OP_SRL:  r = x >> y[4:0];
            OP_SRA:  r = W'(sx >>> y[4:0]);
            OP_MUL:  begin r = p[31:0]; lat = W + 1; end
            OP_MULH: begin r = p[63:32]; lat = W + 1; end
            OP_DIV:  begin
                if (y == 0) r = '1;
                else if (x == MINV && y == '1) r = MINV;
                else begin r = W'(sx / sy); lat = W + 2; end
            end
            OP_REM:  begin
                if (y == 0) r = x;
                else if (x == MINV && y == '1) r = 0;
                else begin r = W'(sx % sy); lat = W + 2; end
            end
            OP_DIVU: begin
                if (y == 0) r = '1;
                else begin r = x / y; lat = W + 2; end
            end
            default: begin
                if (y == 0) r = x;
                else begin r = x % y; lat = W + 2; end
            end
        endcase
        e.res = r;
        e.fl  = {r == 0, r[W-1], c, v};
        e.due = n + lat;
        return e;
    endfunction

    function automatic logic [W-1:0] rv();
        case ($urandom_range(0, 5))
            0: return 0;
            1: return '1;
            2: return MINV;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 8);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("accept", in_ready, 1);
        if (in_ready) begin
            q.push_back(model(o, x, y, cyc));
            acc_log.push_back(cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 300) begin
            @(posedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (busy) chk("busy_blocks_ready", in_ready, 0);
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_output", out_valid, 0);
                else begin
                    if (!seen) begin
                        chk("latency", cyc, q[0].due);
                        seen = 1;
                    end
                    chk("result", result, q[0].res);
                    chk("flags_zncv", {zero, negative, carry, overflow}, q[0].fl);
                    if (!out_ready) chk("ready_while_held", in_ready, 0);
                    else begin
                        q.delete(0);
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        int bc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, negative, carry, overflow}, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);

        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        issue(OP_SUB, 32'd5, 32'd5);
        issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        issue(OP_SRA, 32'h8000_0000, 32'd4);
        issue(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(posedge clk);
            #1;
        end
        chk("mul_busy_cycles", bc, W);
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        issue(OP_REM, 32'hFFFF_FFF9, 32'd2);
        issue(OP_DIVU, 32'd7, 32'd0);
        issue(OP_DIV, MINV, 32'hFFFF_FFFF);
        issue(OP_REM, MINV, 32'hFFFF_FFFF);
        drain();

        rmode = 0;
        out_ready = 1'b0;
        issue(OP_ADD, 32'd100, 32'd23);
        repeat (5) @(posedge clk);
        #1;
        rmode = 1;
        out_ready = 1'b1;
        acc_log.delete();
        for (int i = 0; i < 4; i++) issue(OP_ADD, $urandom, $urandom);
        for (int i = 1; i < 4; i++) chk("back_to_back", acc_log[i] - acc_log[i-1], 1);
        drain();

        issue(OP_DIV, 32'd1000, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        q.delete();
        seen = 0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("abort_in_ready", in_ready, 1);
        issue(OP_DIVU, 32'd1000, 32'd7);
        drain();

        rmode = 2;
        for (int i = 0; i < 300; i++) issue(4'($urandom_range(0, 15)), rv(), rv());
        rmode = 1;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
